// File: rtl/count_event_logger_pkg.sv
// Shared constants and record-layout helpers for the counter event logger.
// Record layout, MSB first: {wrap, match, timestamp, count}.
package count_event_logger_pkg;

    localparam int DROP_W        = 8;
    localparam int REC_COUNT_LSB = 0;

    function automatic int rec_ts_lsb(input int cnt_w);
        return REC_COUNT_LSB + cnt_w;
    endfunction

    function automatic int rec_match_bit(input int cnt_w, input int ts_w);
        return rec_ts_lsb(cnt_w) + ts_w;
    endfunction

    function automatic int rec_wrap_bit(input int cnt_w, input int ts_w);
        return rec_match_bit(cnt_w, ts_w) + 1;
    endfunction

    function automatic int rec_width(input int cnt_w, input int ts_w);
        return cnt_w + ts_w + 2;
    endfunction

endpackage

// File: rtl/count_event_logger_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the head entry.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module sync_fifo_sa #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves occupancy unchanged, including when full.
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/count_event_logger.sv
// Watches the lab counter, timestamps wrap/match events and queues them for
// the reporting logic; events arriving while the queue is full are counted.
module count_event_logger
    import count_event_logger_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [CNT_W-1:0]                 count_in,
    input  logic [CNT_W-1:0]                 cmp_val,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [rec_width(CNT_W,TS_W)-1:0] evt_data,
    output logic [$clog2(DEPTH):0]           level,
    output logic [DROP_W-1:0]                drop_cnt
);

    localparam int REC_W     = rec_width(CNT_W, TS_W);
    localparam int TS_LSB    = rec_ts_lsb(CNT_W);
    localparam int MATCH_BIT = rec_match_bit(CNT_W, TS_W);
    localparam int WRAP_BIT  = rec_wrap_bit(CNT_W, TS_W);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [CNT_W-1:0]  prev_cnt_q, prev_cnt_d;
    logic              prev_vld_q, prev_vld_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              det_en, wrap, match, push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [REC_W-1:0]  rec;

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        prev_cnt_d = prev_cnt_q;
        prev_vld_d = 1'b0;
        if (en) begin
            prev_cnt_d = count_in;
            prev_vld_d = 1'b1;
        end
    end

    // The first enabled cycle only primes prev_cnt, so no event can fire then.
    always_comb begin
        det_en = en & prev_vld_q;
        wrap   = det_en && (prev_cnt_q == {CNT_W{1'b1}}) && (count_in == '0);
        match  = det_en && (count_in == cmp_val) && (count_in != prev_cnt_q);
        push   = wrap | match;
        rec                            = '0;
        rec[REC_COUNT_LSB +: CNT_W]    = count_in;
        rec[TS_LSB +: TS_W]            = ts_q;
        rec[MATCH_BIT]                 = match;
        rec[WRAP_BIT]                  = wrap;
    end

    always_comb begin
        pop        = evt_valid & evt_ready;
        drop       = push & fifo_full & ~pop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {DROP_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            prev_cnt_q <= '0;
            prev_vld_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            prev_cnt_q <= prev_cnt_d;
            prev_vld_q <= prev_vld_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo_sa #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (rec),
        .pop     (pop),
        .rd_data (evt_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign evt_valid = ~fifo_empty;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/count_event_logger.md
Name: count_event_logger

Overview:
- Downstream consumer of the free-running 4-bit lab counter.
- Samples the counter value every enabled cycle and detects two event types:
  - wrap: maximum value followed by zero
  - match: counter enters a programmable compare value
- Each event is timestamped and queued in a small FIFO drained through a valid/ready port toward the UART/LED reporting logic.
- Lost events are counted so software can detect overflow.

Parameters:
CNT_W, 4, width of the observed counter value
DEPTH, 4, FIFO entries; power of two, minimum 2
TS_W, 8, width of the free-running timestamp

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  sampling enable
count_in  input  CNT_W  counter value from the upstream counter
cmp_val  input  CNT_W  compare value for match events; quasi-static
evt_valid  output  1  FIFO head holds a record
evt_ready  input  1  consumer accepts the head record
evt_data  output  TS_W+CNT_W+2  record {wrap, match, timestamp, count}, MSB first
level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
drop_cnt  output  8  events lost while full; saturates at 255

Behaviour:
- Reset is asynchronous, active-high, clock is clk.
  - Reset values: evt_valid=0, evt_data=0, level=0, drop_cnt=0.
  - Timestamp, prev_cnt and prev_vld also reset to 0.
  - Reset mid-operation discards all queued records immediately.
- Timestamp:
  - TS_W-bit counter, +1 every clk regardless of en, wraps 2^TS_W-1 -> 0.
  - A record carries the timestamp value present in the cycle its event is detected.
- Sampling:
  - en=1: prev_cnt <= count_in, prev_vld <= 1 at every edge.
  - en=0: prev_vld <= 0, no detection. The first enabled cycle after en rises only primes prev_cnt.
- Detection (combinational, only when en=1 and prev_vld=1):
  - wrap = (prev_cnt == 2^CNT_W-1) and (count_in == 0)
  - match = (count_in == cmp_val) and (count_in != prev_cnt); a held value does not re-trigger.
  - Both may be set in one record, e.g. cmp_val=0 at wrap. That produces one record, not two.
  - push = wrap | match.
  - Record = {wrap, match, ts, count_in}.
- FIFO:
  - Show-ahead: evt_data always shows the head while evt_valid=1, and is stable while evt_valid=1 and evt_ready=0.
  - pop = evt_valid & evt_ready.
  - push when not full: written at the edge, so evt_valid is 1 the cycle after detection (latency 1).
  - push when full and pop=0: record dropped, drop_cnt +1, saturating at 255.
  - push when full and pop=1: accepted, level stays DEPTH, no drop.
  - push and pop when 0 < level < DEPTH: level unchanged.
  - push when empty: no bypass, evt_valid rises next cycle.
  - evt_ready while empty: ignored.
  - Pointers are log2(DEPTH) bits and wrap naturally. level is tracked explicitly; full = (level == DEPTH).
- The consumer of evt_ready/evt_valid must not depend combinationally on evt_valid. The block never drives evt_valid from evt_ready.
- No state machine beyond FIFO occupancy. All outputs are registered except evt_data, which is a RAM read at the registered read pointer.

Decomposition:
- Shared package holds:
  - record field offsets (REC_COUNT_LSB, REC_TS_LSB, REC_MATCH_BIT, REC_WRAP_BIT)
  - DROP_W=8
  - a function computing the record width from CNT_W/TS_W
- One natural sub-module, sync_fifo_sa:
  - parameterised by width and depth
  - push/pop/full/empty/level, show-ahead read
  - the full-push-with-pop rule lives there
- Detection, timestamp and drop counter stay in count_event_logger.

Test Plan:
1. Reset, then en=1, count_in stepping 0..15,0,1 one per cycle, cmp_val=5, evt_ready=1 -> exactly two records:
   - {0,1,ts,5} the cycle after count_in=5
   - {1,0,ts,0} after 15->0
   - timestamps differ by 11; level returns to 0.
2. cmp_val=0, count_in 15->0 -> single record with wrap=1 and match=1, count=0.
3. evt_ready=0, generate 6 match events (cmp_val toggling counts, 1->5->1->5...) -> level=4, evt_valid=1, head record unchanged throughout, drop_cnt=2; then evt_ready=1 -> 4 records drained in order.
4. FIFO full, event coincides with evt_ready=1 -> level stays 4, drop_cnt unchanged, new record appears last.
5. en deasserted with count_in=15, re-enabled with count_in=0 -> no wrap record (priming cycle); count_in held at cmp_val for 5 cycles -> only one match record.
6. Assert reset while level=3 and drop_cnt=7 -> same-cycle async clear: evt_valid=0, level=0, drop_cnt=0; after release, the first event is recorded normally.
